// File: rtl/branch_cmp_pkg.sv
// Shared types and helpers for the pipelined branch comparator.
package branch_cmp_pkg;

  localparam int CMP_WIDTH_DEFAULT = 32;
  localparam int CMP_CHUNK_DEFAULT = 4;

  // funct3 encodings of the RV32I branch conditions
  typedef enum logic [2:0] {
    OP_EQ   = 3'b000,
    OP_NE   = 3'b001,
    OP_RSV2 = 3'b010,
    OP_RSV3 = 3'b011,
    OP_LT   = 3'b100,
    OP_GE   = 3'b101,
    OP_LTU  = 3'b110,
    OP_GEU  = 3'b111
  } cmp_op_e;

  // Bit n set means funct3 value n is reserved (never taken)
  localparam logic [7:0] CMP_RESERVED = 8'b0000_1100;

  function automatic logic cmp_taken(input logic [2:0] op, input logic lt, input logic eq);
    logic t;
    t = 1'b0;
    if (!CMP_RESERVED[op]) begin
      case (cmp_op_e'(op))
        OP_EQ:          t = eq;
        OP_NE:          t = ~eq;
        OP_LT, OP_LTU:  t = lt;
        OP_GE, OP_GEU:  t = ~lt;
        default:        t = 1'b0;
      endcase
    end
    return t;
  endfunction

endpackage

// File: rtl/branch_cmp_pipe_slice.sv
// One CHUNK-wide slice of the unsigned magnitude cascade; the local slice
// result overrides the cascade coming from less significant slices.
module cmp_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ltIn,
  input  logic             eqIn,
  output logic             ltOut,
  output logic             eqOut
);

  logic sliceLt;
  logic sliceEq;

  // local compare merged with the incoming cascade
  always_comb begin
    sliceLt = (a < b);
    sliceEq = (a == b);
    ltOut   = sliceLt | (sliceEq & ltIn);
    eqOut   = sliceEq & eqIn;
  end

endmodule

// File: rtl/branch_cmp_pipe.sv
// Pipelined RV32I branch comparator (EQ/NE/LT/GE/LTU/GEU) with valid/ready
// handshake and a single global stall. Optional BRANCH_CMP_FLUSH_EN adds
// i_flush to kill all in-flight compares.
module branch_cmp_pipe
  import branch_cmp_pkg::*;
#(
  parameter int WIDTH  = CMP_WIDTH_DEFAULT,
  parameter int CHUNK  = CMP_CHUNK_DEFAULT,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
`ifdef BRANCH_CMP_FLUSH_EN
  input  logic             i_flush,
`endif
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  output logic             o_valid,
  input  logic             i_ready,
  output logic             o_taken,
  output logic             o_lt,
  output logic             o_eq
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int GRP = (NCH + STAGES - 1) / STAGES;

  logic flush;
  logic adv;
  logic en;

`ifdef BRANCH_CMP_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Stage-boundary signals: index s feeds stage s
  logic             vldB  [STAGES];
  logic             ltB   [STAGES];
  logic             eqB   [STAGES];
  logic             aSgnB [STAGES];
  logic             bSgnB [STAGES];
  logic [2:0]       opB   [STAGES];
  logic [WIDTH-1:0] aBus  [STAGES];
  logic [WIDTH-1:0] bBus  [STAGES];

  logic vldOut;
  logic takenOut;
  logic ltOut;
  logic eqOut;

  assign adv     = ~vldOut | i_ready;
  assign en      = adv | flush;
  assign o_ready = adv | flush;
  assign o_valid = vldOut;
  assign o_taken = takenOut;
  assign o_lt    = ltOut;
  assign o_eq    = eqOut;

  assign vldB[0]  = i_valid;
  assign ltB[0]   = 1'b0;
  assign eqB[0]   = 1'b1;
  assign aSgnB[0] = i_a[WIDTH-1];
  assign bSgnB[0] = i_b[WIDTH-1];
  assign opB[0]   = i_op;
  assign aBus[0]  = i_a;
  assign bBus[0]  = i_b;

  for (genvar s = 0; s < STAGES; s++) begin : gStage
    localparam int LO   = (s * GRP < NCH) ? s * GRP : NCH;
    localparam int HI   = ((s + 1) * GRP < NCH) ? (s + 1) * GRP : NCH;
    localparam int KEEP = HI * CHUNK;

    logic [GRP:0] ltC;
    logic [GRP:0] eqC;

    assign ltC[0] = ltB[s];
    assign eqC[0] = eqB[s];

    for (genvar j = 0; j < GRP; j++) begin : gSlice
      if (LO + j < HI) begin : gOn
        cmp_slice #(.CHUNK(CHUNK)) uSlice (
          .a     (aBus[s][(LO + j) * CHUNK +: CHUNK]),
          .b     (bBus[s][(LO + j) * CHUNK +: CHUNK]),
          .ltIn  (ltC[j]),
          .eqIn  (eqC[j]),
          .ltOut (ltC[j + 1]),
          .eqOut (eqC[j + 1])
        );
      end else begin : gPass
        assign ltC[j + 1] = ltC[j];
        assign eqC[j + 1] = eqC[j];
      end
    end

    if (s < STAGES - 1) begin : gMid
      logic       vldQ;
      logic       ltQ;
      logic       eqQ;
      logic       aSgnQ;
      logic       bSgnQ;
      logic [2:0] opQ;

      // cascade state register; valid clears on reset or flush
      always_ff @(posedge i_clk) begin
        if (i_reset)    vldQ <= 1'b0;
        else if (flush) vldQ <= 1'b0;
        else if (adv)   vldQ <= vldB[s];
        if (en) begin
          ltQ   <= ltC[GRP];
          eqQ   <= eqC[GRP];
          opQ   <= opB[s];
          aSgnQ <= aSgnB[s];
          bSgnQ <= bSgnB[s];
        end
      end

      assign vldB[s + 1]  = vldQ;
      assign ltB[s + 1]   = ltQ;
      assign eqB[s + 1]   = eqQ;
      assign opB[s + 1]   = opQ;
      assign aSgnB[s + 1] = aSgnQ;
      assign bSgnB[s + 1] = bSgnQ;

      if (KEEP < WIDTH) begin : gKeep
        logic [WIDTH-1:KEEP] aQ;
        logic [WIDTH-1:KEEP] bQ;

        // only operand bits still to be compared travel downstream
        always_ff @(posedge i_clk) begin
          if (en) begin
            aQ <= aBus[s][WIDTH-1:KEEP];
            bQ <= bBus[s][WIDTH-1:KEEP];
          end
        end

        assign aBus[s + 1] = {aQ, {KEEP{1'b0}}};
        assign bBus[s + 1] = {bQ, {KEEP{1'b0}}};
      end else begin : gDone
        assign aBus[s + 1] = '0;
        assign bBus[s + 1] = '0;
      end
    end else begin : gLast
      logic ult;
      logic slt;
      logic ltSel;

      // signedness fix-up: differing sign bits decide the signed order
      always_comb begin
        ult   = ltC[GRP];
        slt   = (aSgnB[s] ^ bSgnB[s]) ? aSgnB[s] : ult;
        ltSel = opB[s][1] ? ult : slt;
      end

      // registered result stage
      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          vldOut   <= 1'b0;
          takenOut <= 1'b0;
          ltOut    <= 1'b0;
          eqOut    <= 1'b0;
        end else begin
          if (flush)    vldOut <= 1'b0;
          else if (adv) vldOut <= vldB[s];
          if (en) begin
            takenOut <= cmp_taken(opB[s], ltSel, eqC[GRP]);
            ltOut    <= ltSel;
            eqOut    <= eqC[GRP];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_branch_cmp_pipe.sv
// Self-checking bench for branch_cmp_pipe: vector table, reset, stall
// streaming with a scoreboard, and flush (with BRANCH_CMP_FLUSH_EN).
module tb_branch_cmp_pipe;
  localparam int WIDTH  = 32;
  localparam int CHUNK  = 4;
  localparam int STAGES = 3;
  localparam int NV     = 15;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [2:0]       i_op;
  logic             o_valid;
  logic             i_ready;
  logic             o_taken;
  logic             o_lt;
  logic             o_eq;
  logic             tbFlush;

  int checks = 0;
  int errors = 0;
  int popped = 0;

  typedef struct packed {
    logic taken;
    logic lt;
    logic eq;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        taken;
    logic        lt;
    logic        eq;
  } vec_t;

  res_t sb[$];
  vec_t vec[NV];

  always #5 i_clk = ~i_clk;

  branch_cmp_pipe #(.WIDTH(WIDTH), .CHUNK(CHUNK), .STAGES(STAGES)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
`ifdef BRANCH_CMP_FLUSH_EN
    .i_flush (tbFlush),
`endif
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_a     (i_a),
    .i_b     (i_b),
    .i_op    (i_op),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_taken (o_taken),
    .o_lt    (o_lt),
    .o_eq    (o_eq)
  );

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic [2:0] op);
    res_t r;
    logic ult;
    logic slt;
    r.eq = (a == b);
    ult  = (a < b);
    slt  = ($signed(a) < $signed(b));
    r.lt = op[1] ? ult : slt;
    case (op)
      3'b000:         r.taken = r.eq;
      3'b001:         r.taken = ~r.eq;
      3'b100, 3'b110: r.taken = r.lt;
      3'b101, 3'b111: r.taken = ~r.lt;
      default:        r.taken = 1'b0;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: push on input transfer, pop/compare on output transfer
  res_t heldVal;
  logic heldOn = 1'b0;
  always @(negedge i_clk) begin : monitor
    res_t e;
    if (i_reset) begin
      sb.delete();
      heldOn = 1'b0;
    end else begin
      if (o_valid && !i_ready) begin
        if (heldOn) chk("hold_stable", {29'd0, o_taken, o_lt, o_eq}, {29'd0, heldVal});
        heldVal = {o_taken, o_lt, o_eq};
        heldOn  = 1'b1;
      end else begin
        heldOn = 1'b0;
      end
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got output %0h expected no output", {o_taken, o_lt, o_eq});
        end else begin
          e = sb.pop_front();
          chk("sb_result", {29'd0, o_taken, o_lt, o_eq}, {29'd0, e});
          popped++;
        end
      end
      if (tbFlush) sb.delete();
      else if (i_valid && o_ready) sb.push_back(model(i_a, i_b, i_op));
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int wt;

    vec[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b100, 1'b1, 1'b1, 1'b0};
    vec[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b110, 1'b0, 1'b0, 1'b0};
    vec[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 1'b0, 1'b1, 1'b0};
    vec[3]  = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b100, 1'b0, 1'b0, 1'b0};
    vec[4]  = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b110, 1'b1, 1'b1, 1'b0};
    vec[5]  = '{32'h0000_0001, 32'hFFFF_FFFF, 3'b101, 1'b1, 1'b0, 1'b0};
    vec[6]  = '{32'h8000_0000, 32'h8000_0000, 3'b000, 1'b1, 1'b0, 1'b1};
    vec[7]  = '{32'h8000_0000, 32'h8000_0000, 3'b001, 1'b0, 1'b0, 1'b1};
    vec[8]  = '{32'h8000_0000, 32'h0000_0000, 3'b100, 1'b1, 1'b1, 1'b0};
    vec[9]  = '{32'h8000_0000, 32'h0000_0000, 3'b111, 1'b1, 1'b0, 1'b0};
    vec[10] = '{32'h0000_0001, 32'h0000_0002, 3'b010, 1'b0, 1'b1, 1'b0};
    vec[11] = '{32'h0000_0001, 32'h0000_0002, 3'b011, 1'b0, 1'b1, 1'b0};
    vec[12] = '{32'h1234_5678, 32'h1234_5679, 3'b110, 1'b1, 1'b1, 1'b0};
    vec[13] = '{32'h2234_5678, 32'h1234_5678, 3'b101, 1'b1, 1'b0, 1'b0};
    vec[14] = '{32'h0000_000F, 32'h0000_0010, 3'b100, 1'b1, 1'b1, 1'b0};

    i_reset = 1'b1;
    i_valid = 1'b1;
    i_a     = '1;
    i_b     = '0;
    i_op    = 3'b000;
    i_ready = 1'b1;
    tbFlush = 1'b0;

    // reset held three cycles with a valid input present
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk); #1;
      chk("rst_o_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_outs", {29'd0, o_taken, o_lt, o_eq}, 32'd0);
    end
    i_reset = 1'b0;
    i_valid = 1'b0;
    @(negedge i_clk);
    chk("rst_o_ready", {31'd0, o_ready}, 32'd1);

    // table vectors, one op at a time with latency measurement
    for (int i = 0; i < NV; i++) begin
      @(posedge i_clk); #1;
      i_a     = vec[i].a;
      i_b     = vec[i].b;
      i_op    = vec[i].op;
      i_valid = 1'b1;
      @(posedge i_clk); #1;
      i_valid = 1'b0;
      lat = 1;
      while (!o_valid && lat < 20) begin
        @(posedge i_clk); #1;
        lat++;
      end
      chk($sformatf("vec%0d_latency", i), lat, STAGES);
      chk($sformatf("vec%0d_taken", i), {31'd0, o_taken}, {31'd0, vec[i].taken});
      chk($sformatf("vec%0d_lt", i), {31'd0, o_lt}, {31'd0, vec[i].lt});
      chk($sformatf("vec%0d_eq", i), {31'd0, o_eq}, {31'd0, vec[i].eq});
    end

    // reset while an op is in flight: it must never emerge
    @(posedge i_clk); #1;
    i_a = 32'd5; i_b = 32'd7; i_op = 3'b100; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    for (int c = 0; c < STAGES + 2; c++) begin
      @(negedge i_clk);
      chk("rstmid_no_valid", {31'd0, o_valid}, 32'd0);
    end

    // back-to-back stream of 8 random ops with i_ready low in cycles 3..5
    @(posedge i_clk); #1;
    popped = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          i_a     = $urandom;
          i_b     = (k % 3 == 0) ? i_a : $urandom;
          i_op    = 3'($urandom_range(0, 7));
          i_valid = 1'b1;
          wt = 0;
          do begin
            @(negedge i_clk);
            wt++;
          end while (!o_ready && wt < 50);
          if (!o_ready) begin
            checks++;
            errors++;
            $display("FAIL stream_accept: got o_ready 0 expected 1 within 50 cycles");
          end
          @(posedge i_clk); #1;
        end
        i_valid = 1'b0;
      end
      begin
        repeat (3) begin @(posedge i_clk); #1; end
        i_ready = 1'b0;
        repeat (3) begin @(posedge i_clk); #1; end
        i_ready = 1'b1;
      end
    join
    wt = 0;
    while (popped < 8 && wt < 100) begin
      @(posedge i_clk); #1;
      wt++;
    end
    chk("stream_count", popped, 8);
    repeat (5) @(posedge i_clk);
    #1;
    chk("stream_nodup", popped, 8);

`ifdef BRANCH_CMP_FLUSH_EN
    // two ops in flight, then flush; a fresh op afterwards completes normally
    @(posedge i_clk); #1;
    i_a = 32'd1; i_b = 32'd2; i_op = 3'b100; i_valid = 1'b1;
    @(posedge i_clk); #1;
    i_a = 32'd3; i_b = 32'd3; i_op = 3'b000;
    @(posedge i_clk); #1;
    i_a = 32'd9; i_b = 32'd1; i_op = 3'b101;
    tbFlush = 1'b1;
    @(negedge i_clk);
    chk("flush_ready", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk); #1;
    tbFlush = 1'b0;
    i_a = 32'h4; i_b = 32'h4; i_op = 3'b000;
    @(negedge i_clk);
    chk("flush_no_valid", {31'd0, o_valid}, 32'd0);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk); #1;
      lat++;
    end
    chk("flush_next_latency", lat, STAGES);
    chk("flush_next_taken", {31'd0, o_taken}, 32'd1);
    chk("flush_next_eq", {31'd0, o_eq}, 32'd1);
`endif

    repeat (STAGES + 2) @(posedge i_clk);
    #1;
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
